// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write arbiter.
// Optional statistics counters are enabled by FIFO_WR_ARB_STATS_EN.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int BURST_CNT_W = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_owner.
// Returns both a one-hot pick and its binary index.
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_owner,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] index
);

    logic w_found;
    int   w_j;

    always_comb begin
        pick    = '0;
        index   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int i = 1; i <= N; i++) begin
            w_j = (int'(last_owner) + i) % N;
            if (!w_found && req[w_j[IW-1:0]]) begin
                w_found               = 1'b1;
                pick[w_j[IW-1:0]]     = 1'b1;
                index                 = w_j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding N_REQ producers into one FIFO write port.
// Define FIFO_WR_ARB_STATS_EN to add wr_total / stall_cnt counters.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] data,
    output logic [N_REQ-1:0]    ack,
    output logic [N_REQ-1:0]    gnt,
    input  logic                fifo_full,
    output logic                fifo_wr,
    output logic [DW-1:0]       fifo_din,
    output logic                busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [15:0]         wr_total,
    output logic [15:0]         stall_cnt
`endif
);

    localparam int IW = idx_w(N_REQ);

    state_t                 r_state;
    logic [N_REQ-1:0]       r_gnt;
    logic [IW-1:0]          r_last_owner;
    logic [BURST_CNT_W-1:0] r_cnt;

    logic [N_REQ-1:0]       w_pick;
    logic [IW-1:0]          w_idx;
    logic                   w_own_req;
    logic                   w_wr;
    logic [BURST_CNT_W-1:0] w_cnt_nx;
    logic                   w_last_beat;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req        (req),
        .last_owner (r_last_owner),
        .pick       (w_pick),
        .index      (w_idx)
    );

    assign w_own_req   = |(req & r_gnt);
    assign w_wr        = (r_state == BURST) && w_own_req && !fifo_full;
    assign w_cnt_nx    = r_cnt + BURST_CNT_W'(1);
    assign w_last_beat = (w_cnt_nx == BURST_CNT_W'(BURST_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_gnt        <= '0;
            r_last_owner <= IW'(N_REQ - 1);
            r_cnt        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_gnt        <= w_pick;
                        r_last_owner <= w_idx;
                        r_cnt        <= '0;
                        r_state      <= BURST;
                    end
                end
                BURST: begin
                    // Owner withdrawal wins over a pending full stall.
                    if (!w_own_req) begin
                        r_gnt   <= '0;
                        r_state <= IDLE;
                    end else if (w_wr) begin
                        r_cnt <= w_cnt_nx;
                        if (w_last_beat) begin
                            r_gnt   <= '0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        fifo_din = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_gnt[k]) fifo_din = fifo_din | data[k*DW +: DW];
        end
    end

    assign ack     = w_wr ? r_gnt : '0;
    assign gnt     = r_gnt;
    assign fifo_wr = w_wr;
    assign busy    = (r_state == BURST);

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] r_wr_total;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_total  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_wr) r_wr_total <= r_wr_total + 16'd1;
            if ((r_state == BURST) && w_own_req && fifo_full
                && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign wr_total  = r_wr_total;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter (N_REQ=4, DW=8, BURST_MAX=4).
// Stats checks run only when FIFO_WR_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*DW-1:0] data;
    logic [N-1:0]  ack;
    logic [N-1:0]  gnt;
    logic          fifo_full;
    logic          fifo_wr;
    logic [DW-1:0] fifo_din;
    logic          busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0]   wr_total;
    logic [15:0]   stall_cnt;
`endif

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .DW        (DW),
        .BURST_MAX (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data      (data),
        .ack       (ack),
        .gnt       (gnt),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_din  (fifo_din),
        .busy      (busy)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .wr_total  (wr_total),
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [DW-1:0] pq [N][$];
    logic [DW-1:0] sb [$];
    int            glog [$];
    int            wlog [$];
    int            n_wr;

    logic [N-1:0]  prev_gnt;
    logic [N-1:0]  s_gnt;
    logic [N-1:0]  s_ack;
    logic          s_wr;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req[k] = (pq[k].size() != 0);
            data[k*DW +: DW] = (pq[k].size() != 0) ? pq[k][0] : '0;
        end
    endtask

    task automatic put(input int k, input logic [DW-1:0] w);
        pq[k].push_back(w);
        drive();
    endtask

    task automatic load(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            put(k, DW'(k*16 + i));
            sb.push_back(DW'(k*16 + i));
        end
    endtask

    task automatic clr_logs();
        glog.delete();
        wlog.delete();
        n_wr = 0;
    endtask

    task automatic cyc();
        logic [N-1:0] hs;
        @(negedge clk);
        s_gnt = gnt;
        s_ack = ack;
        s_wr  = fifo_wr;
        if (gnt != 0 && prev_gnt == 0) begin
            glog.push_back(idx_of(gnt));
            wlog.push_back(0);
        end
        prev_gnt = gnt;
        chk("ack_owner", 32'(ack & ~gnt), 0);
        chk("wr_full", 32'(fifo_wr & fifo_full), 0);
        if (fifo_wr) begin
            n_wr++;
            if (wlog.size() > 0)
                wlog[wlog.size()-1] = wlog[wlog.size()-1] + 1;
            if (sb.size() == 0) chk("sb_extra", 1, 0);
            else chk("din", 32'(fifo_din), 32'(sb.pop_front()));
        end
        hs = req & ack;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++)
            if (hs[k]) void'(pq[k].pop_front());
        drive();
    endtask

    task automatic run_idle(input int max);
        bit done = 0;
        for (int i = 0; i < max && !done; i++) begin
            cyc();
            done = (req == 0) && !busy && (gnt == 0);
        end
        chk("timeout", 32'(done), 1);
        chk("sb_left", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < N; k++) pq[k].delete();
        sb.delete();
        drive();
        prev_gnt = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        fifo_full = 1'b0;
        req = '0;
        data = '0;
        prev_gnt = '0;
        clr_logs();

        // Reset state
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_wr", 32'(fifo_wr), 0);
        chk("rst_din", 32'(fifo_din), 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single producer, 6 words: bursts 4 + 2
        clr_logs();
        load(0, 6);
        cyc();
        chk("s1_lat0", 32'(s_gnt), 0);
        cyc();
        chk("s1_lat1", 32'(s_gnt), 1);
        chk("s1_wr1", 32'(s_wr), 1);
        run_idle(40);
        chk("s1_ngnt", glog.size(), 2);
        chk("s1_g1", qget(glog, 1), 0);
        chk("s1_b0", qget(wlog, 0), 4);
        chk("s1_b1", qget(wlog, 1), 2);

        // Round robin: all four requesting, owner 0 has one extra word
        do_reset();
        clr_logs();
        for (int k = 0; k < N; k++)
            for (int i = 0; i < 4; i++) begin
                put(k, DW'(8'h80 + k*16 + i));
                sb.push_back(DW'(8'h80 + k*16 + i));
            end
        put(0, 8'hF0);
        sb.push_back(8'hF0);
        run_idle(80);
        chk("rr_n", glog.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr_g%0d", i), qget(glog, i), i % 4);
        chk("rr_b4", qget(wlog, 4), 1);
        chk("rr_wr", n_wr, 17);

        // Owner 2 stalled by full for 3 cycles mid-burst
        clr_logs();
        load(2, 6);
        cyc();
        cyc();
        cyc();
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("st_wr", 32'(s_wr), 0);
            chk("st_ack", 32'(s_ack), 0);
            chk("st_gnt", 32'(s_gnt), 32'h4);
        end
        fifo_full = 1'b0;
        run_idle(40);
        chk("st_n", glog.size(), 2);
        chk("st_b0", qget(wlog, 0), 4);
        chk("st_b1", qget(wlog, 1), 2);

        // Owner 3 drops after 2 words; requester 1 follows
        clr_logs();
        load(3, 2);
        load(1, 2);
        cyc();
        chk("dr_c0", 32'(s_gnt), 0);
        cyc();
        chk("dr_c1", 32'(s_gnt), 32'h8);
        cyc();
        chk("dr_c2", 32'(s_wr), 1);
        cyc();
        chk("dr_c3g", 32'(s_gnt), 32'h8);
        chk("dr_c3w", 32'(s_wr), 0);
        cyc();
        chk("dr_c4", 32'(s_gnt), 0);
        cyc();
        chk("dr_c5", 32'(s_gnt), 32'h2);
        run_idle(40);
        chk("dr_g0", qget(glog, 0), 3);
        chk("dr_g1", qget(glog, 1), 1);

        // Asynchronous reset mid-burst
        clr_logs();
        load(0, 4);
        cyc();
        cyc();
        #2;
        rst = 1'b1;
        #1;
        chk("ar_gnt", 32'(gnt), 0);
        chk("ar_ack", 32'(ack), 0);
        chk("ar_wr", 32'(fifo_wr), 0);
        chk("ar_din", 32'(fifo_din), 0);
        chk("ar_busy", 32'(busy), 0);
        for (int k = 0; k < N; k++) pq[k].delete();
        sb.delete();
        drive();
        prev_gnt = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clr_logs();
        load(1, 1);
        load(2, 1);
        run_idle(40);
        chk("ar_g0", qget(glog, 0), 1);
        chk("ar_g1", qget(glog, 1), 2);

`ifdef FIFO_WR_ARB_STATS_EN
        do_reset();
        clr_logs();
        load(0, 10);
        cyc();
        cyc();
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        fifo_full = 1'b0;
        run_idle(60);
        chk("wr_total", 32'(wr_total), 10);
        chk("stall_cnt", 32'(stall_cnt), 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
